// File: rtl/regfile_if.sv
// Register-file access bus: two combinational read ports and one write port.
// The decode/writeback side is master; the register file is slave.
interface regfile_if #(
    parameter int WIDTH      = 64,
    parameter int DEPTH_LOG2 = 5
);
    logic                  reg_write;
    logic [DEPTH_LOG2-1:0] write_register;
    logic [WIDTH-1:0]      write_data;
    logic [DEPTH_LOG2-1:0] read_register1;
    logic [DEPTH_LOG2-1:0] read_register2;
    logic [WIDTH-1:0]      read_data1;
    logic [WIDTH-1:0]      read_data2;

    // Write: reg_write qualifies write_register/write_data at each rising clk edge;
    // there is no ready, the write always completes. Reads have no handshake.
    modport master (
        output reg_write, write_register, write_data, read_register1, read_register2,
        input  read_data1, read_data2
    );

    modport slave (
        input  reg_write, write_register, write_data, read_register1, read_register2,
        output read_data1, read_data2
    );
endinterface

// File: rtl/regfile.sv
// LEGv8 32-entry register file: X0..X30 stored in enable-gated registers,
// X31 (XZR) reads as zero and ignores writes. Async active-high reset.
module regfile #(
    parameter int WIDTH      = 64,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic      clk,
    input  logic      reset,
    regfile_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DEPTH-2:0] wen;
    logic [WIDTH-1:0] rd_arr [DEPTH];

    // One-hot write decoder; index DEPTH-1 (XZR) has no enable line at all.
    always_comb begin
        wen = '0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            wen[i] = bus.reg_write && (bus.write_register == i[DEPTH_LOG2-1:0]);
        end
    end

    for (genvar g = 0; g < DEPTH - 1; g++) begin : g_reg
        logic [WIDTH-1:0] data_q;
        logic [WIDTH-1:0] data_d;

        always_comb begin
            data_d = data_q;
            if (wen[g]) begin
                data_d = bus.write_data;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end

        assign rd_arr[g] = data_q;
    end

    assign rd_arr[DEPTH-1] = '0;

    // No write-to-read bypass: forwarding is handled by the ID stage.
    assign bus.read_data1 = rd_arr[bus.read_register1];
    assign bus.read_data2 = rd_arr[bus.read_register2];
endmodule
